// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared encodings for the multi-cycle MIPS core: instruction opcode and
//   function-field constants, the 4-bit ALU operation codes (also consumed by
//   the ALU), and the control bundle produced by the main decoder.
//
//   Contents:
//     OP_*      6-bit primary opcodes (instruction bits [31:26])
//     FN_*      6-bit R-type function codes (instruction bits [5:0])
//     ALU_*     4-bit ALU operation codes
//     ctrl_t    packed control bundle driven by control_decode
//     CTRL_NOP  bundle value for reset and for any unrecognised instruction
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // ALU operation codes (1000, 1011 and 1111 are deliberately unused)
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_ADDU = 4'b0100;
    localparam logic [3:0] ALU_SUBU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MULT = 4'b1001;
    localparam logic [3:0] ALU_DIV  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1101;
    localparam logic [3:0] ALU_LUI  = 4'b1110;

    // Control bundle handed from the decoder to the output register
    typedef struct packed {
        logic       reg_dst;     // 1: write rd, 0: write rt
        logic       alu_src_b;   // 1: ALU B is the sign-extended immediate
        logic       mem_to_reg;  // 1: writeback from data memory
        logic       jump;        // select jump target for next PC
        logic       branch;      // branch candidate (qualified by ALU Zero)
        logic       reg_write;   // register-file write enable
        logic [3:0] alu_ctrl;    // ALU operation code
        logic       mem_read;    // data-memory read strobe
        logic       mem_write;   // data-memory write strobe
    } ctrl_t;

    // Reset / NOP bundle: no strobes, ALU left at ADD so address paths idle
    // on a harmless operation.
    localparam ctrl_t CTRL_NOP = '{
        reg_dst:    1'b0,
        alu_src_b:  1'b0,
        mem_to_reg: 1'b0,
        jump:       1'b0,
        branch:     1'b0,
        reg_write:  1'b0,
        alu_ctrl:   ALU_ADD,
        mem_read:   1'b0,
        mem_write:  1'b0
    };

    // R-type bundle: rd destination, register B operand, ALU writeback.
    // MULT/DIV pass wr=0 because their result lands only in Hi/Lo.
    function automatic ctrl_t ctrl_rtype(input logic [3:0] alu, input logic wr);
        ctrl_t c;
        c           = CTRL_NOP;
        c.reg_dst   = 1'b1;
        c.reg_write = wr;
        c.alu_ctrl  = alu;
        return c;
    endfunction

    // Immediate ALU bundle: rt destination, immediate B operand, ALU writeback.
    function automatic ctrl_t ctrl_imm(input logic [3:0] alu);
        ctrl_t c;
        c           = CTRL_NOP;
        c.alu_src_b = 1'b1;
        c.reg_write = 1'b1;
        c.alu_ctrl  = alu;
        return c;
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// -----------------------------------------------------------------------------
// control_decode
//   Purely combinational main decoder: maps opcode and function field to the
//   control bundle. Anything not recognised decodes to CTRL_NOP, so a write
//   strobe can never be raised by an illegal instruction.
//
//   Ports:
//     opcode_i  in  6   instruction bits [31:26]
//     funct_i   in  6   instruction bits [5:0] (used only for R-type)
//     ctrl_o    out     decoded control bundle (cpu_pkg::ctrl_t)
// -----------------------------------------------------------------------------
module control_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o
);

    ctrl_t rtype_ctrl;

    // R-type function decode kept separate so the opcode case stays flat.
    always_comb begin
        rtype_ctrl = CTRL_NOP;
        case (funct_i)
            FN_ADD:  rtype_ctrl = ctrl_rtype(ALU_ADD,  1'b1);
            FN_ADDU: rtype_ctrl = ctrl_rtype(ALU_ADDU, 1'b1);
            FN_SUB:  rtype_ctrl = ctrl_rtype(ALU_SUB,  1'b1);
            FN_SUBU: rtype_ctrl = ctrl_rtype(ALU_SUBU, 1'b1);
            FN_AND:  rtype_ctrl = ctrl_rtype(ALU_AND,  1'b1);
            FN_OR:   rtype_ctrl = ctrl_rtype(ALU_OR,   1'b1);
            FN_XOR:  rtype_ctrl = ctrl_rtype(ALU_XOR,  1'b1);
            FN_NOR:  rtype_ctrl = ctrl_rtype(ALU_NOR,  1'b1);
            FN_SLT:  rtype_ctrl = ctrl_rtype(ALU_SLT,  1'b1);
            FN_SLTU: rtype_ctrl = ctrl_rtype(ALU_SLTU, 1'b1);
            // Hi/Lo producers: same datapath setup, no register-file write
            FN_MULT: rtype_ctrl = ctrl_rtype(ALU_MULT, 1'b0);
            FN_DIV:  rtype_ctrl = ctrl_rtype(ALU_DIV,  1'b0);
            default: rtype_ctrl = CTRL_NOP;
        endcase
    end

    always_comb begin
        ctrl_o = CTRL_NOP;
        case (opcode_i)
            OP_RTYPE: ctrl_o = rtype_ctrl;
            OP_ADDI:  ctrl_o = ctrl_imm(ALU_ADD);
            OP_ADDIU: ctrl_o = ctrl_imm(ALU_ADDU);
            OP_ANDI:  ctrl_o = ctrl_imm(ALU_AND);
            OP_ORI:   ctrl_o = ctrl_imm(ALU_OR);
            OP_XORI:  ctrl_o = ctrl_imm(ALU_XOR);
            OP_SLTI:  ctrl_o = ctrl_imm(ALU_SLT);
            OP_SLTIU: ctrl_o = ctrl_imm(ALU_SLTU);
            OP_LUI:   ctrl_o = ctrl_imm(ALU_LUI);
            OP_LW: begin
                // Address = base + offset, then load into rt
                ctrl_o            = ctrl_imm(ALU_ADD);
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.mem_read   = 1'b1;
            end
            OP_SW: begin
                // Address = base + offset; store never writes the register file
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_ctrl  = ALU_ADD;
            end
            OP_BEQ: begin
                // Compare rs - rt; PC logic qualifies Branch with ALU Zero
                ctrl_o.branch   = 1'b1;
                ctrl_o.alu_ctrl = ALU_SUB;
            end
            OP_J: begin
                ctrl_o.jump = 1'b1;
            end
            default: ctrl_o = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Main decoder of the multi-cycle MIPS core. The combinational decode of
//   OPcode/Func is captured every rising edge, so controls for an instruction
//   are valid one edge after its fields are stable and held until the next
//   edge. reset_n forces the NOP bundle asynchronously.
//
//   Ports:
//     clk          in   1  rising-edge clock
//     reset_n      in   1  asynchronous active-low reset
//     OPcode       in   6  instruction bits [31:26]
//     Func         in   6  instruction bits [5:0]
//     RegDst       out  1  1=write rd, 0=write rt
//     ALUSrc_B     out  1  1=ALU B is sign-extended immediate
//     MemtoReg     out  1  1=writeback from data memory
//     Jump         out  1  select jump target
//     Branch       out  1  branch candidate
//     RegWrite     out  1  register-file write enable
//     ALU_Control  out  4  ALU operation code
//     MemRead      out  1  data-memory read strobe
//     MemWrite     out  1  data-memory write strobe
// -----------------------------------------------------------------------------
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] OPcode,
    input  logic [5:0] Func,
    output logic       RegDst,
    output logic       ALUSrc_B,
    output logic       MemtoReg,
    output logic       Jump,
    output logic       Branch,
    output logic       RegWrite,
    output logic [3:0] ALU_Control,
    output logic       MemRead,
    output logic       MemWrite
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .opcode_i (OPcode),
        .funct_i  (Func),
        .ctrl_o   (ctrl_d)
    );

    // No enable: a fresh decode is captured on every edge out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign RegDst      = ctrl_q.reg_dst;
    assign ALUSrc_B    = ctrl_q.alu_src_b;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign Jump        = ctrl_q.jump;
    assign Branch      = ctrl_q.branch;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALU_Control = ctrl_q.alu_ctrl;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic       clk;
    logic       reset_n;
    logic [5:0] OPcode;
    logic [5:0] Func;
    logic       RegDst, ALUSrc_B, MemtoReg, Jump, Branch, RegWrite;
    logic [3:0] ALU_Control;
    logic       MemRead, MemWrite;

    control_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .OPcode      (OPcode),
        .Func        (Func),
        .RegDst      (RegDst),
        .ALUSrc_B    (ALUSrc_B),
        .MemtoReg    (MemtoReg),
        .Jump        (Jump),
        .Branch      (Branch),
        .RegWrite    (RegWrite),
        .ALU_Control (ALU_Control),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {RegDst,ALUSrc_B,MemtoReg,Jump,Branch,RegWrite,ALU[3:0],MemRead,MemWrite}
    logic [11:0] outs;
    assign outs = {RegDst, ALUSrc_B, MemtoReg, Jump, Branch, RegWrite,
                   ALU_Control, MemRead, MemWrite};

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [11:0] exp_of(input bit rd, input bit sb, input bit m2r,
                                           input bit j, input bit br, input bit rw,
                                           input logic [3:0] alu, input bit mr, input bit mw);
        return {rd, sb, m2r, j, br, rw, alu, mr, mw};
    endfunction

    localparam logic [11:0] NOP_EXP = 12'b0_0_0_0_0_0_0010_0_0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %b required %b", name, act, exp);
        else begin
            n_pass++;
            $display("ok   %s: %b", name, act);
        end
    endtask

    task automatic chk_bit(input string name, input bit ok);
        n_total++;
        if (!ok) $display("FAIL %s: outputs %b violate rule", name, outs);
        else     n_pass++;
    endtask

    // ---------------- reference model (instruction-class tables) ----------------
    // kind: 0 nop, 1 R-type, 2 immediate ALU, 3 load, 4 store, 5 beq, 6 jump
    int         op_kind [64];
    logic [3:0] op_alu  [64];
    bit         fn_ok   [64];
    bit         fn_wr   [64];
    logic [3:0] fn_alu  [64];

    task automatic init_model();
        for (int i = 0; i < 64; i++) begin
            op_kind[i] = 0; op_alu[i] = 4'd2; fn_ok[i] = 0; fn_wr[i] = 0; fn_alu[i] = 4'd2;
        end
        op_kind[0]  = 1;
        op_kind[8]  = 2; op_alu[8]  = 4'd2;   // addi
        op_kind[9]  = 2; op_alu[9]  = 4'd4;   // addiu
        op_kind[12] = 2; op_alu[12] = 4'd0;   // andi
        op_kind[13] = 2; op_alu[13] = 4'd1;   // ori
        op_kind[14] = 2; op_alu[14] = 4'd3;   // xori
        op_kind[10] = 2; op_alu[10] = 4'd7;   // slti
        op_kind[11] = 2; op_alu[11] = 4'd13;  // sltiu
        op_kind[15] = 2; op_alu[15] = 4'd14;  // lui
        op_kind[35] = 3;                       // lw
        op_kind[43] = 4;                       // sw
        op_kind[4]  = 5;                       // beq
        op_kind[2]  = 6;                       // j
        // funct 32..39: add addu sub subu and or xor nor
        fn_alu[32] = 4'd2; fn_alu[33] = 4'd4; fn_alu[34] = 4'd6;  fn_alu[35] = 4'd5;
        fn_alu[36] = 4'd0; fn_alu[37] = 4'd1; fn_alu[38] = 4'd3;  fn_alu[39] = 4'd12;
        fn_alu[42] = 4'd7; fn_alu[43] = 4'd13;
        foreach (fn_alu[i]) if ((i >= 32 && i <= 39) || i == 42 || i == 43) begin
            fn_ok[i] = 1; fn_wr[i] = 1;
        end
        fn_ok[24] = 1; fn_alu[24] = 4'd9;   // mult, no write
        fn_ok[26] = 1; fn_alu[26] = 4'd10;  // div, no write
    endtask

    function automatic logic [11:0] model(input logic [5:0] op, input logic [5:0] fn);
        case (op_kind[op])
            1: return fn_ok[fn] ? exp_of(1, 0, 0, 0, 0, fn_wr[fn], fn_alu[fn], 0, 0) : NOP_EXP;
            2: return exp_of(0, 1, 0, 0, 0, 1, op_alu[op], 0, 0);
            3: return exp_of(0, 1, 1, 0, 0, 1, 4'd2, 1, 0);
            4: return exp_of(0, 1, 0, 0, 0, 0, 4'd2, 0, 1);
            5: return exp_of(0, 0, 0, 0, 1, 0, 4'd6, 0, 0);
            6: return exp_of(0, 0, 0, 1, 0, 0, 4'd2, 0, 0);
            default: return NOP_EXP;
        endcase
    endfunction

    // Drive new fields at the falling edge, check 1 ns after the rising edge.
    task automatic apply(input logic [5:0] op, input logic [5:0] fn,
                         input logic [11:0] exp, input string name);
        @(negedge clk);
        OPcode = op;
        Func   = fn;
        @(posedge clk);
        #1;
        chk(name, outs, exp);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];
    logic [5:0] legal_ops[13];

    initial begin
        init_model();
        vecs[0]  = '{6'b000000, 6'b100010, exp_of(1,0,0,0,0,1,4'b0110,0,0), "r_sub"};
        vecs[1]  = '{6'b000000, 6'b101010, exp_of(1,0,0,0,0,1,4'b0111,0,0), "r_slt"};
        vecs[2]  = '{6'b000000, 6'b011000, exp_of(1,0,0,0,0,0,4'b1001,0,0), "r_mult"};
        vecs[3]  = '{6'b000000, 6'b011010, exp_of(1,0,0,0,0,0,4'b1010,0,0), "r_div"};
        vecs[4]  = '{6'b000000, 6'b100111, exp_of(1,0,0,0,0,1,4'b1100,0,0), "r_nor"};
        vecs[5]  = '{6'b001101, 6'b111111, exp_of(0,1,0,0,0,1,4'b0001,0,0), "ori"};
        vecs[6]  = '{6'b001111, 6'b000000, exp_of(0,1,0,0,0,1,4'b1110,0,0), "lui"};
        vecs[7]  = '{6'b001011, 6'b000000, exp_of(0,1,0,0,0,1,4'b1101,0,0), "sltiu"};
        vecs[8]  = '{6'b100011, 6'b000000, exp_of(0,1,1,0,0,1,4'b0010,1,0), "lw"};
        vecs[9]  = '{6'b101011, 6'b000000, exp_of(0,1,0,0,0,0,4'b0010,0,1), "sw"};
        vecs[10] = '{6'b000100, 6'b000000, exp_of(0,0,0,0,1,0,4'b0110,0,0), "beq"};
        vecs[11] = '{6'b000010, 6'b000000, exp_of(0,0,0,1,0,0,4'b0010,0,0), "j"};
        vecs[12] = '{6'b111111, 6'b100000, NOP_EXP, "illegal_op"};
        vecs[13] = '{6'b000000, 6'b000001, NOP_EXP, "illegal_func"};
        legal_ops = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13,
                      6'd14, 6'd15, 6'd35, 6'd43};

        // ---- reset held: outputs pinned regardless of inputs and clock ----
        reset_n = 1'b0;
        OPcode  = 6'b100011;
        Func    = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            #3;
            OPcode = 6'($urandom);
            Func   = 6'($urandom);
            #4;
            chk("reset_hold", outs, NOP_EXP);
        end

        // ---- release between edges: nothing changes until the next edge ----
        @(negedge clk);
        OPcode  = 6'b100011;
        Func    = 6'b000000;
        reset_n = 1'b1;
        #1;
        chk("release_no_change", outs, NOP_EXP);
        @(posedge clk);
        #1;
        chk("first_edge_lw", outs, model(6'b100011, 6'b000000));

        // ---- inputs changing between edges are ignored until the edge ----
        @(negedge clk);
        OPcode = 6'b101011;
        #2;
        chk("hold_between_edges", outs, exp_of(0,1,1,0,0,1,4'b0010,1,0));
        @(posedge clk);
        #1;
        chk("lw_then_sw", outs, exp_of(0,1,0,0,0,0,4'b0010,0,1));

        // ---- asynchronous reset mid-operation ----
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", outs, NOP_EXP);
        @(negedge clk);
        OPcode  = 6'b000100;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_beq", outs, exp_of(0,0,0,0,1,0,4'b0110,0,0));

        // ---- directed table ----
        foreach (vecs[i]) apply(vecs[i].op, vecs[i].fn, vecs[i].exp, vecs[i].name);

        // ---- randomized against the class-table model plus invariants ----
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 1) == 0) ? legal_ops[$urandom_range(0, 12)] : 6'($urandom);
            fn = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(32, 43)) : 6'($urandom);
            apply(op, fn, model(op, fn), $sformatf("rand op=%b fn=%b", op, fn));
            chk_bit("excl_mem_rd_wr", !(MemRead && MemWrite));
            chk_bit("excl_jump_branch", !(Jump && Branch));
            chk_bit("excl_store_write", !(MemWrite && RegWrite));
            chk_bit("alu_code_used", !(ALU_Control inside {4'b1000, 4'b1011, 4'b1111}));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder for the multi-cycle MIPS core.
- Maps the 6-bit opcode and 6-bit function field of the current instruction to datapath control strobes and a 4-bit ALU operation code.
- Outputs are registered: one clock edge after OPcode/Func are stable, the controls for that instruction are valid and held.
- Drives register-file destination select, ALU B-operand select, writeback select, PC jump/branch selects, register-file write enable, and data-memory read/write.

Parameters:
- none (all encodings are fixed constants in the shared package)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- OPcode  in  6  instruction bits [31:26]
- Func  in  6  instruction bits [5:0]; only meaningful when OPcode=000000
- RegDst  out  1  1=write rd (IR[15:11]), 0=write rt (IR[20:16])
- ALUSrc_B  out  1  1=ALU B is sign-extended immediate, 0=rt data
- MemtoReg  out  1  1=writeback from data memory, 0=from ALU result
- Jump  out  1  select jump target for next PC
- Branch  out  1  branch candidate; PC takes branch target when Branch & ALU Zero
- RegWrite  out  1  register-file write enable
- ALU_Control  out  4  ALU operation code
- MemRead  out  1  data-memory read strobe
- MemWrite  out  1  data-memory write strobe

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (reset_n).
- Reset: while reset_n=0, every 1-bit output is 0 and ALU_Control=4'b0010 (ADD), independent of clk.
- Each rising edge with reset_n=1 registers the decode of the current OPcode/Func.
  - Latency is exactly 1 cycle.
  - Outputs hold between edges.
  - No enable input; decoding occurs every cycle.
- ALU_Control codes: AND 0000, OR 0001, ADD 0010, XOR 0011, ADDU 0100, SUBU 0101, SUB 0110, SLT 0111, MULT 1001, DIV 1010, NOR 1100, SLTU 1101, LUI 1110.
  - 1000, 1011 and 1111 are unused and never emitted.
- R-type, OPcode 000000:
  - RegDst=1, ALUSrc_B=0, MemtoReg=0, RegWrite=1, all other strobes 0.
  - Func map: 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU.
  - Func 011000 MULT and 011010 DIV: same strobes but RegWrite=0 (result goes only to ALU Hi/Lo).
  - Any other Func: treated as NOP (see Unknown opcode).
- Immediate ALU ops: RegDst=0, ALUSrc_B=1, RegWrite=1, MemtoReg=0.
  - OPcode map: 001000 addi→ADD, 001001 addiu→ADDU, 001100 andi→AND, 001101 ori→OR, 001110 xori→XOR, 001010 slti→SLT, 001011 sltiu→SLTU, 001111 lui→LUI.
- 100011 lw: ALUSrc_B=1, MemtoReg=1, RegWrite=1, MemRead=1, RegDst=0, ALU ADD.
- 101011 sw: ALUSrc_B=1, MemWrite=1, RegWrite=0, ALU ADD.
- 000100 beq: Branch=1, ALU SUB, ALUSrc_B=0, no writes.
- 000010 j: Jump=1, no writes, ALU ADD.
- Unknown opcode (or unknown Func): NOP. All strobes 0, ALU_Control=ADD; a write is never asserted.
- Mutual exclusion, guaranteed in every state: MemRead and MemWrite never both 1; Jump and Branch never both 1; RegWrite=0 whenever MemWrite=1.
- Reset mid-operation: outputs go to reset values immediately. The first post-reset edge decodes the inputs present at that edge.
- Inputs changing between edges have no effect until the next edge.

Decomposition:
- Shared package cpu_pkg holds: opcode constants, Func constants, ALU_Control code constants (also used by ALU), and a control-bundle struct typedef.
- One natural sub-module: control_decode.
  - Purely combinational opcode/Func → control bundle.
  - control_unit wraps it with the reset-able output register.

Test Plan:
- Reset: hold reset_n=0 and toggle inputs → all strobes 0, ALU_Control=0010. Deassert between edges → outputs unchanged until the next rising edge.
- R-type sweep: OPcode=000000 with Func=100010 → after 1 edge RegDst=1, RegWrite=1, ALU_Control=0110. Func=101010 → 0111. Func=011000 → 1001 with RegWrite=0.
- Immediate/LUI: OPcode=001101 → ALUSrc_B=1, RegWrite=1, RegDst=0, ALU_Control=0001. OPcode=001111 → ALU_Control=1110.
- Memory: OPcode=100011 → MemRead=1, MemtoReg=1, RegWrite=1, ALU=0010. Next cycle OPcode=101011 → MemWrite=1, MemRead=0, RegWrite=0.
- Control flow: OPcode=000100 → Branch=1, ALU=0110, Jump=0. OPcode=000010 → Jump=1, Branch=0, RegWrite=0.
- Illegal: OPcode=111111, and OPcode=000000 with Func=000001 → all strobes 0, ALU_Control=0010. Assert the exclusion invariants every cycle under random OPcode/Func.
